serial_mag_comp: RTL
====================

// Module: serial_mag_comp
//
// PURPOSE
// - Parametrised, bit-serial N-bit magnitude comparator. It is the multi-bit successor of the
//   combinational one-bit comparator.
// - It captures two WIDTH-bit operands on a start pulse and scans them MSB-first, one bit per
//   clock. It reports lt/gt/eq with a one-cycle valid pulse.
// - It sits between an operand source using a start/busy handshake and a result consumer.
//
// PARAMETERS
// - WIDTH   8   operand width in bits; legal range 2..64.
// - SIGNED  0   0 = unsigned compare; 1 = two's-complement compare.
//
// PORTS
// - clk     in   1      rising-edge clock
// - rst_n   in   1      synchronous reset, active low
// - start   in   1      request; sampled only while busy=0
// - a       in   WIDTH  operand A; captured on an accepted start
// - b       in   WIDTH  operand B; captured on an accepted start
// - busy    out  1      compare in progress; new start is ignored
// - valid   out  1      one-cycle pulse; lt/gt/eq are final
// - lt      out  1      A < B
// - gt      out  1      A > B
// - eq      out  1      A == B
//
// BEHAVIOUR
// - Reset (rst_n=0 at a rising edge): busy=0, valid=0, lt=0, gt=0, eq=0. FSM goes to IDLE and
//   the bit counter clears.
// - FSM states:
//   - IDLE: on start=1, capture a and b into shift regs, set count=WIDTH-1 and busy=1, clear
//     lt/gt/eq, then go to RUN.
//   - RUN: each edge examines bit[count] of the captured A and B.
//     - While no difference has been found yet, the first differing bit decides the result.
//       Unsigned: A bit 1 gives gt, else lt.
//       SIGNED=1 and the difference is at the MSB: the sense is inverted (A MSB 1 gives lt).
//     - Later bits never change a decided result.
//     - When count reaches 0, the FSM goes to DONE.
//   - DONE: valid=1 and busy=0 for exactly one cycle. eq=1 if no difference was found.
//     The FSM returns to IDLE.
// - Latency: capture at edge k. valid is high during the cycle after edge k+WIDTH, i.e.
//   WIDTH+1 cycles from start to valid.
// - Exactly one of lt/gt/eq is 1 from the valid pulse onward. All three are 0 while busy=1.
// - Results are held after valid until the next accepted start.
// - start during RUN: ignored, with no effect on the operands or the result.
// - start during DONE: accepted. Capture happens on the same edge that leaves DONE, so
//   back-to-back compares have no idle gap.
// - a/b changing after capture: no effect.
// - Reset mid-RUN: the operation is aborted, no valid pulse is produced, and all outputs take
//   their reset values on that edge.
// - Counter width: $clog2(WIDTH). The count never wraps; the decrement is guarded at 0.
//
// CONFIGURATION
// - Macro SERIAL_MAG_COMP_EARLY_EXIT_EN.
// - Defined: RUN goes to DONE on the edge that finds the first differing bit.
//   - Latency = (MSB index - differing bit index) + 2 cycles.
//   - Equal operands still take the full WIDTH+1 cycles.
// - Undefined: fixed latency of WIDTH+1 cycles for every operand pair. Use this where
//   constant timing is required.
// - lt/gt/eq values are identical in both builds.
//
// TESTING  (WIDTH=8 unless noted)
// 1. Reset: hold rst_n=0 for 2 cycles -> busy=valid=lt=gt=eq=0. start is ignored while
//    rst_n=0.
// 2. Equal operands: a=8'h5A, b=8'h5A, start -> busy=1 for 8 cycles, then valid=1 for one
//    cycle with eq=1, lt=0, gt=0. eq stays 1 afterwards.
// 3. MSB difference: a=8'h80, b=8'h7F -> SIGNED=0 gives gt=1; SIGNED=1 gives lt=1. Both valid
//    at 9 cycles.
// 4. Start while busy: a=3, b=5, start; 2 cycles later a=9, start -> single valid with lt=1,
//    taken from the first operands. A start in the DONE cycle with a=9, b=5 gives gt=1 nine
//    cycles later.
// 5. Reset mid-op: start with a=1, b=2; assert rst_n=0 at the 3rd RUN edge -> all outputs 0,
//    no valid pulse. The next start completes normally.
// 6. Early exit (macro defined): a=8'h80, b=8'h00 gives valid 2 cycles after start with gt=1;
//    a=8'h01, b=8'h00 gives valid at 9 cycles. Without the macro both take 9 cycles.

Source files
------------

// File: rtl/serial_mag_comp.sv
// -----------------------------------------------------------------------------
// serial_mag_comp
//
// Bit-serial WIDTH-bit magnitude comparator. Two operands are captured on an
// accepted start pulse and scanned MSB-first, one bit per clock. The first
// differing bit decides the result. Once the scan ends, a one-cycle valid pulse
// marks lt/gt/eq as final. Results then hold until the next accepted start.
//
// Parameters
//   WIDTH   operand width in bits, 2..64
//   SIGNED  0 = unsigned compare, 1 = two's-complement compare
//
// Ports
//   clk     in   1      rising-edge clock
//   rst_n   in   1      synchronous reset, active low
//   start   in   1      request; only honoured while busy=0 (IDLE or DONE)
//   a       in   WIDTH  operand A, captured on an accepted start
//   b       in   WIDTH  operand B, captured on an accepted start
//   busy    out  1      compare in progress; start is ignored
//   valid   out  1      one-cycle pulse; lt/gt/eq are final
//   lt      out  1      A < B
//   gt      out  1      A > B
//   eq      out  1      A == B
//
// Build option
//   SERIAL_MAG_COMP_EARLY_EXIT_EN
//     Defined:   RUN ends on the edge that finds the first differing bit.
//                Latency = (MSB index - differing bit index) + 2 cycles.
//     Undefined: constant latency of WIDTH+1 cycles for every operand pair.
//   lt/gt/eq values are identical in both builds.
// -----------------------------------------------------------------------------
module serial_mag_comp #(
  parameter int WIDTH  = 8,
  parameter bit SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             valid,
  output logic             lt,
  output logic             gt,
  output logic             eq
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               found_q, found_d;
  logic               dec_gt_q, dec_gt_d;
  logic               busy_q, busy_d;
  logic               valid_q, valid_d;
  logic               lt_q, lt_d;
  logic               gt_q, gt_d;
  logic               eq_q, eq_d;

  logic               bit_a_s;
  logic               bit_b_s;
  logic               diff_s;
  logic               at_msb_s;
  logic               bit_gt_s;
  logic               hit_s;
  logic               last_s;
  logic               finish_s;
  logic               fin_found_s;
  logic               fin_gt_s;
  logic               accept_s;

  // Bit-slice evaluation of the current scan position.
  always_comb begin
    // The shift registers move left each RUN edge, so the bit at
    // position cnt_q of the captured operand always sits in the MSB slot.
    bit_a_s  = a_sh_q[WIDTH-1];
    bit_b_s  = b_sh_q[WIDTH-1];
    diff_s   = bit_a_s ^ bit_b_s;
    at_msb_s = (cnt_q == CNT_MAX);
    // A sign-bit difference means the operand with the 1 is negative,
    // so the sense flips in two's-complement mode.
    if (SIGNED && at_msb_s) begin
      bit_gt_s = bit_b_s;
    end else begin
      bit_gt_s = bit_a_s;
    end
    hit_s       = diff_s & ~found_q;
    last_s      = (cnt_q == CNT_ZERO);
    fin_found_s = found_q | diff_s;
    fin_gt_s    = found_q ? dec_gt_q : bit_gt_s;
`ifdef SERIAL_MAG_COMP_EARLY_EXIT_EN
    finish_s    = last_s | hit_s;
`else
    finish_s    = last_s;
`endif
    // busy is low in IDLE and DONE, so a start there is taken.
    accept_s    = start & (state_q != S_RUN);
  end

  // Next-state and next-output logic of the compare FSM.
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    cnt_d    = cnt_q;
    found_d  = found_q;
    dec_gt_d = dec_gt_q;
    busy_d   = busy_q;
    valid_d  = 1'b0;
    lt_d     = lt_q;
    gt_d     = gt_q;
    eq_d     = eq_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept_s) begin
          state_d  = S_RUN;
          a_sh_d   = a;
          b_sh_d   = b;
          cnt_d    = CNT_MAX;
          found_d  = 1'b0;
          dec_gt_d = 1'b0;
          busy_d   = 1'b1;
          lt_d     = 1'b0;
          gt_d     = 1'b0;
          eq_d     = 1'b0;
        end else begin
          state_d  = S_IDLE;
          busy_d   = 1'b0;
        end
      end

      S_RUN: begin
        // Only the first difference is recorded; later bits are ignored.
        if (hit_s) begin
          found_d  = 1'b1;
          dec_gt_d = bit_gt_s;
        end else begin
          found_d  = found_q;
          dec_gt_d = dec_gt_q;
        end

        if (finish_s) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          valid_d = 1'b1;
          gt_d    = fin_found_s & fin_gt_s;
          lt_d    = fin_found_s & ~fin_gt_s;
          eq_d    = ~fin_found_s;
        end else begin
          state_d = S_RUN;
          a_sh_d  = {a_sh_q[WIDTH-2:0], 1'b0};
          b_sh_d  = {b_sh_q[WIDTH-2:0], 1'b0};
          // Guarded decrement: the counter never wraps below zero.
          if (cnt_q != CNT_ZERO) begin
            cnt_d = cnt_q - CNT_ONE;
          end else begin
            cnt_d = cnt_q;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        lt_d    = 1'b0;
        gt_d    = 1'b0;
        eq_d    = 1'b0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand shifters, bit counter, decision flags and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh_q   <= {WIDTH{1'b0}};
      b_sh_q   <= {WIDTH{1'b0}};
      cnt_q    <= CNT_ZERO;
      found_q  <= 1'b0;
      dec_gt_q <= 1'b0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      lt_q     <= 1'b0;
      gt_q     <= 1'b0;
      eq_q     <= 1'b0;
    end else begin
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      cnt_q    <= cnt_d;
      found_q  <= found_d;
      dec_gt_q <= dec_gt_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
      lt_q     <= lt_d;
      gt_q     <= gt_d;
      eq_q     <= eq_d;
    end
  end

  assign busy  = busy_q;
  assign valid = valid_q;
  assign lt    = lt_q;
  assign gt    = gt_q;
  assign eq    = eq_q;

endmodule
